// File: rtl/framebuffer_scan_reader_if.sv
// Bundle of the frame request handshake, framebuffer RAM read port and pixel stream
// used by framebuffer_scan_reader. The master side is the reader itself.
interface framebuffer_scan_reader_if;
  logic        req;
  logic        ack;
  logic        busy;
  logic        re;
  logic [15:0] raddr;
  logic [7:0]  rdata;
  logic [7:0]  gdata;
  logic [7:0]  bdata;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sol;
  logic        pix_eof;

  modport master (
    input  req, rdata, gdata, bdata, pix_ready,
    output ack, busy, re, raddr, pix_rgb, pix_valid, pix_sol, pix_eof
  );

  modport slave (
    output req, rdata, gdata, bdata, pix_ready,
    input  ack, busy, re, raddr, pix_rgb, pix_valid, pix_sol, pix_eof
  );
endinterface

// File: rtl/framebuffer_scan_reader.sv
// Raster-order framebuffer reader: scans {y,x} on a req/ack handshake and streams
// RGB pixels with start-of-line / end-of-frame tags through a 2-entry skid FIFO.
module framebuffer_scan_reader #(
  parameter logic [7:0] H_LAST = 8'd255,
  parameter logic [7:0] V_LAST = 8'd255
) (
  input logic                       clk,
  input logic                       rst,
  framebuffer_scan_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e      state_q;
  logic [7:0]  x_q;
  logic [7:0]  y_q;
  logic        ack_q;
  logic        busy_q;

  logic        inflight_q;
  logic        tag_sol_q;
  logic        tag_eof_q;

  logic [25:0] mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  logic        push;
  logic        pop;
  logic        issue;
  logic        last_pix;
  logic [1:0]  occupancy;

  assign push     = inflight_q;
  assign pop      = (count_q != 2'd0) && bus.pix_ready;
  assign last_pix = (x_q == H_LAST) && (y_q == V_LAST);

  // A pop on this edge frees a slot for the read issued now; without that credit the
  // stream could not sustain one pixel per cycle with only two entries.
  assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue     = (state_q == StRead) && (occupancy < 2'd2);

  assign bus.re    = issue;
  assign bus.raddr = issue ? {y_q, x_q} : 16'h0000;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

  assign bus.pix_valid = (count_q != 2'd0);
  assign {bus.pix_sol, bus.pix_eof, bus.pix_rgb} = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req) begin
            state_q <= StRead;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StRead: begin
          if (issue) begin
            // Explicit compare so a full 256-wide line does not depend on 8-bit wrap.
            if (x_q == H_LAST) begin
              x_q <= 8'd0;
              y_q <= y_q + 8'd1;
            end else begin
              x_q <= x_q + 8'd1;
            end
            if (last_pix) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if ((count_q == 2'd0) && !inflight_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (!bus.req) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      tag_sol_q  <= 1'b0;
      tag_eof_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_sol_q <= (x_q == 8'd0);
        tag_eof_q <= last_pix;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {tag_sol_q, tag_eof_q, bus.rdata, bus.gdata, bus.bdata};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && (count_q == 2'd2)))
    else $error("framebuffer_scan_reader: push into full FIFO");

endmodule
